trans_block_summary: RTL and testbench

//  Downstream of the transaction validator. Consumes each accepted 128-bit

---
 rtl/trans_block_summary.sv | 177 +++++++++++++++++
 tb/tb_trans_block_summary.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trans_block_summary.sv
// Per-block transaction statistics with a summary FIFO toward the ledger side.
// Summary visible the cycle after the closing edge; input never stalls, full FIFO drops summaries.

module sum_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level;
  logic             do_wr, do_rd;

  assign rd_vld = (level != '0);
  assign do_rd  = rd_vld & rd_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign wr_rdy = (level != (AW+1)'(DEPTH)) | do_rd;
  assign do_wr  = wr_vld & wr_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module trans_block_summary #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int SUM_W      = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [127:0]     data_i,
  input  logic             valid_i,
  input  logic             flush_i,
  output logic             sum_valid_o,
  input  logic             sum_ready_i,
  output logic [15:0]      sum_block_o,
  output logic [CNT_W-1:0] sum_count_o,
  output logic [SUM_W-1:0] sum_total_o,
  output logic [31:0]      sum_hash_o,
  output logic             overflow_o
);
  typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} state_t;

  typedef struct packed {
    logic [15:0]      blk;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] tot;
    logic [31:0]      hash;
  } sum_t;

  state_t         state, nxt_state;
  sum_t           cur, head;
  logic [15:0]    blk_cnt;
  logic           flush_pend, flush_any;
  logic           do_open, do_accum, do_close;
  logic           fifo_wr_rdy;
  logic [21:0]    amount;
  logic           start;
  logic [31:0]    fold;
  logic [CNT_W-1:0] cnt_sat;
  logic [SUM_W:0]   tot_wide;
  logic [SUM_W-1:0] tot_sat;

  assign amount    = data_i[31:10];
  assign start     = data_i[9];
  assign fold      = data_i[127:96] ^ data_i[95:64] ^ data_i[63:32] ^ data_i[31:0];
  // A pending flush waits for a cycle without a transaction.
  assign flush_any = (flush_i | flush_pend) & ~valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (valid_i) nxt_state = OPEN;
      OPEN:    if (flush_any) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    do_open  = 1'b0;
    do_accum = 1'b0;
    do_close = 1'b0;
    case (state)
      IDLE: do_open = valid_i;
      OPEN: begin
        if (valid_i) begin
          do_close = start;
          do_open  = start;
          do_accum = ~start;
        end else begin
          do_close = flush_any;
        end
      end
      default: ;
    endcase
  end

  assign cnt_sat  = (&cur.cnt) ? cur.cnt : cur.cnt + 1'b1;
  assign tot_wide = {1'b0, cur.tot} + (SUM_W+1)'(amount);
  assign tot_sat  = tot_wide[SUM_W] ? {SUM_W{1'b1}} : tot_wide[SUM_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= '0;
      blk_cnt    <= '0;
      flush_pend <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      flush_pend <= valid_i ? (flush_pend | flush_i) : 1'b0;
      if (do_close) blk_cnt <= blk_cnt + 16'd1;
      if (do_close && !fifo_wr_rdy) overflow_o <= 1'b1;
      if (do_open) begin
        // On close-and-reopen the new block takes the id after the one just closed.
        cur.blk  <= do_close ? blk_cnt + 16'd1 : blk_cnt;
        cur.cnt  <= CNT_W'(1);
        cur.tot  <= SUM_W'(amount);
        cur.hash <= fold;
      end else if (do_accum) begin
        cur.cnt  <= cnt_sat;
        cur.tot  <= tot_sat;
        cur.hash <= {cur.hash[30:0], cur.hash[31]} ^ fold;
      end
    end
  end

  sum_fifo #(
    .WIDTH($bits(sum_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (do_close),
    .wr_dat (cur),
    .wr_rdy (fifo_wr_rdy),
    .rd_vld (sum_valid_o),
    .rd_rdy (sum_ready_i),
    .rd_dat (head)
  );

  assign sum_block_o = head.blk;
  assign sum_count_o = head.cnt;
  assign sum_total_o = head.tot;
  assign sum_hash_o  = head.hash;
endmodule

// File: tb/tb_trans_block_summary.sv
// Scoreboard bench for trans_block_summary: a behavioural block model queues
// expected summaries as transactions are driven; pops are compared in order.
module tb_trans_block_summary;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] data_i = '0;
  logic         valid_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         sum_ready_i = 1'b0;
  logic         sum_valid_o;
  logic [15:0]  sum_block_o;
  logic [15:0]  sum_count_o;
  logic [39:0]  sum_total_o;
  logic [31:0]  sum_hash_o;
  logic         overflow_o;

  int total = 0;
  int bad = 0;

  trans_block_summary #(.FIFO_DEPTH(4), .CNT_W(16), .SUM_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .flush_i(flush_i),
    .sum_valid_o(sum_valid_o), .sum_ready_i(sum_ready_i), .sum_block_o(sum_block_o),
    .sum_count_o(sum_count_o), .sum_total_o(sum_total_o), .sum_hash_o(sum_hash_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Behavioural model of the open block and the summary FIFO contents.
  logic [103:0] exp_q[$];
  bit           m_open, m_pend, m_ovf;
  logic [15:0]  m_blk, m_id, m_cnt;
  logic [39:0]  m_tot;
  logic [31:0]  m_hash;

  function automatic logic [31:0] fold(input logic [127:0] d);
    return d[127:96] ^ d[95:64] ^ d[63:32] ^ d[31:0];
  endfunction

  function automatic void m_reset();
    m_open = 0; m_pend = 0; m_ovf = 0; m_blk = '0; m_id = '0;
    m_cnt = '0; m_tot = '0; m_hash = '0;
    exp_q.delete();
  endfunction

  function automatic void m_close();
    if (exp_q.size() < 4) exp_q.push_back({m_id, m_cnt, m_tot, m_hash});
    else m_ovf = 1;
    m_blk = m_blk + 16'd1;
    m_open = 0;
  endfunction

  function automatic void m_txn(input logic [127:0] d, input bit fl);
    if (m_open && !d[9]) begin
      m_cnt  = (m_cnt == 16'hffff) ? m_cnt : m_cnt + 16'd1;
      m_tot  = m_tot + 40'(d[31:10]);
      m_hash = {m_hash[30:0], m_hash[31]} ^ fold(d);
    end else begin
      if (m_open) m_close();
      m_open = 1; m_id = m_blk; m_cnt = 16'd1; m_tot = 40'(d[31:10]); m_hash = fold(d);
    end
    if (fl) m_pend = 1;
  endfunction

  function automatic logic [103:0] exp_pop();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; valid_i = 0; flush_i = 0; sum_ready_i = 0; data_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  task automatic send(input bit st, input int amt, input bit fl);
    logic [127:0] d;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    d[31:10] = 22'(amt);
    d[9] = st;
    @(posedge clk); #1;
    data_i = d; valid_i = 1'b1; flush_i = fl;
    m_txn(d, fl);
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    // The next edge has no transaction, so a pending flush is taken there.
    if (m_pend) begin
      if (m_open) m_close();
      m_pend = 0;
    end
  endtask

  task automatic flush();
    @(posedge clk); #1 flush_i = 1'b1;
    if (m_open) m_close();
    m_pend = 0;
    @(posedge clk); #1 flush_i = 1'b0;
  endtask

  // Takes one summary off the DUT; ok=0 when none appeared within the budget.
  task automatic pop_one(output logic [103:0] got, output bit ok);
    ok = 0; got = 'x;
    @(posedge clk); #1 sum_ready_i = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (sum_valid_o) begin
        got = {sum_block_o, sum_count_o, sum_total_o, sum_hash_o};
        ok = 1;
      end
    end
    @(posedge clk); #1 sum_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (sum_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", sum_valid_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow_o); end
    total++;
    if ({sum_block_o, sum_count_o, sum_total_o, sum_hash_o} !== 104'd0) begin
      bad++; $display("FAIL rst_fields got=%h exp=0", {sum_block_o, sum_count_o, sum_total_o, sum_hash_o});
    end
  endtask

  task automatic test_basic();
    logic [103:0] got, e; bit ok;
    do_reset();
    send(1, 5, 0); send(0, 7, 0); send(0, 9, 0);
    @(negedge clk);
    total++; if (sum_valid_o !== 1'b0) begin bad++; $display("FAIL t1_early got=%b exp=0", sum_valid_o); end
    flush();
    @(negedge clk);
    total++; if (sum_valid_o !== 1'b1) begin bad++; $display("FAIL t1_valid_next got=%b exp=1", sum_valid_o); end
    pop_one(got, ok); e = exp_pop();
    total++; if (!ok || got !== e) begin bad++; $display("FAIL t1_sum got=%h exp=%h ok=%0d", got, e, ok); end
    total++; if (got[103:32] !== {16'd0, 16'd3, 40'd21}) begin bad++; $display("FAIL t1_const got=%h exp=%h", got[103:32], {16'd0, 16'd3, 40'd21}); end
    // Back in IDLE, a non-start transaction opens a fresh block.
    send(0, 2, 0); flush();
    pop_one(got, ok); e = exp_pop();
    total++; if (!ok || got !== e) begin bad++; $display("FAIL t1_idle_open got=%h exp=%h ok=%0d", got, e, ok); end
    total++; if (got[103:32] !== {16'd1, 16'd1, 40'd2}) begin bad++; $display("FAIL t1_idle_const got=%h exp=%h", got[103:32], {16'd1, 16'd1, 40'd2}); end
  endtask

  task automatic test_two_blocks();
    logic [103:0] got, e; bit ok;
    logic [71:0] want [2];
    want[0] = {16'd0, 16'd2, 40'd30};
    want[1] = {16'd1, 16'd1, 40'd30};
    do_reset();
    send(1, 10, 0); send(0, 20, 0); send(1, 30, 0); flush();
    for (int k = 0; k < 2; k++) begin
      pop_one(got, ok); e = exp_pop();
      total++; if (!ok || got !== e) begin bad++; $display("FAIL t2_sum%0d got=%h exp=%h ok=%0d", k, got, e, ok); end
      total++; if (got[103:32] !== want[k]) begin bad++; $display("FAIL t2_const%0d got=%h exp=%h", k, got[103:32], want[k]); end
    end
  endtask

  task automatic test_flush_with_txn();
    logic [103:0] got, e; bit ok;
    do_reset();
    send(1, 6, 0); send(0, 4, 1);
    pop_one(got, ok); e = exp_pop();
    total++; if (!ok || got !== e) begin bad++; $display("FAIL t3_sum got=%h exp=%h ok=%0d", got, e, ok); end
    total++; if (got[103:32] !== {16'd0, 16'd2, 40'd10}) begin bad++; $display("FAIL t3_const got=%h exp=%h", got[103:32], {16'd0, 16'd2, 40'd10}); end
    repeat (2) @(negedge clk);
    total++; if (sum_valid_o !== 1'b0) begin bad++; $display("FAIL t3_single got=%b exp=0", sum_valid_o); end
  endtask

  task automatic test_overflow();
    logic [103:0] got, e; bit ok;
    do_reset();
    for (int k = 1; k <= 5; k++) send(1, k, 0);
    flush();
    @(negedge clk);
    total++; if (overflow_o !== 1'b1 || !m_ovf) begin bad++; $display("FAIL t4_ovf got=%b exp=1", overflow_o); end
    total++;
    if ({sum_block_o, sum_count_o, sum_total_o, sum_hash_o} !== exp_q[0]) begin
      bad++; $display("FAIL t4_head got=%h exp=%h", {sum_block_o, sum_count_o, sum_total_o, sum_hash_o}, exp_q[0]);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({sum_block_o, sum_count_o, sum_total_o, sum_hash_o} !== exp_q[0]) begin
      bad++; $display("FAIL t4_hold got=%h exp=%h", {sum_block_o, sum_count_o, sum_total_o, sum_hash_o}, exp_q[0]);
    end
    for (int k = 0; k < 4; k++) begin
      pop_one(got, ok); e = exp_pop();
      total++; if (!ok || got !== e) begin bad++; $display("FAIL t4_drain%0d got=%h exp=%h ok=%0d", k, got, e, ok); end
      total++; if (got[103:88] !== 16'(k)) begin bad++; $display("FAIL t4_id%0d got=%0d exp=%0d", k, got[103:88], k); end
    end
    @(negedge clk);
    total++; if (sum_valid_o !== 1'b0) begin bad++; $display("FAIL t4_empty got=%b exp=0", sum_valid_o); end
    send(1, 7, 0); flush();
    pop_one(got, ok); e = exp_pop();
    total++; if (!ok || got !== e) begin bad++; $display("FAIL t4_next got=%h exp=%h ok=%0d", got, e, ok); end
    total++; if (got[103:88] !== 16'd5) begin bad++; $display("FAIL t4_next_id got=%0d exp=5", got[103:88]); end
  endtask

  task automatic test_full_push_pop();
    logic [103:0] got, e; bit ok;
    do_reset();
    for (int k = 11; k <= 15; k++) send(1, k, 0);
    @(posedge clk); #1 flush_i = 1'b1; sum_ready_i = 1'b1;
    @(negedge clk);
    got = {sum_block_o, sum_count_o, sum_total_o, sum_hash_o};
    e = exp_pop();
    total++; if (sum_valid_o !== 1'b1 || got !== e) begin bad++; $display("FAIL t5_head got=%h exp=%h", got, e); end
    @(posedge clk); #1 flush_i = 1'b0; sum_ready_i = 1'b0;
    m_close();
    @(negedge clk);
    total++; if (overflow_o !== 1'b0 || m_ovf) begin bad++; $display("FAIL t5_no_ovf got=%b exp=0", overflow_o); end
    for (int k = 0; k < 4; k++) begin
      pop_one(got, ok); e = exp_pop();
      total++; if (!ok || got !== e) begin bad++; $display("FAIL t5_drain%0d got=%h exp=%h ok=%0d", k, got, e, ok); end
    end
    total++; if (got[103:32] !== {16'd4, 16'd1, 40'd15}) begin bad++; $display("FAIL t5_tail got=%h exp=%h", got[103:32], {16'd4, 16'd1, 40'd15}); end
    flush();
    repeat (3) @(negedge clk);
    total++; if (sum_valid_o !== 1'b0) begin bad++; $display("FAIL t5_idle_flush got=%b exp=0", sum_valid_o); end
    send(0, 3, 0);
    repeat (3) @(negedge clk);
    total++; if (sum_valid_o !== 1'b0) begin bad++; $display("FAIL t5_pend_clear got=%b exp=0", sum_valid_o); end
  endtask

  task automatic test_reset_mid();
    logic [103:0] got, e; bit ok;
    do_reset();
    for (int k = 1; k <= 6; k++) send(1, k, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    total++; if (sum_valid_o !== 1'b0) begin bad++; $display("FAIL t6_valid got=%b exp=0", sum_valid_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL t6_ovf got=%b exp=0", overflow_o); end
    total++; if (sum_count_o !== 16'd0) begin bad++; $display("FAIL t6_count got=%0d exp=0", sum_count_o); end
    #2 rst_n = 1'b1;
    m_reset();
    send(1, 3, 0); flush();
    pop_one(got, ok); e = exp_pop();
    total++; if (!ok || got !== e) begin bad++; $display("FAIL t6_sum got=%h exp=%h ok=%0d", got, e, ok); end
    total++; if (got[103:32] !== {16'd0, 16'd1, 40'd3}) begin bad++; $display("FAIL t6_const got=%h exp=%h", got[103:32], {16'd0, 16'd1, 40'd3}); end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic();
    test_two_blocks();
    test_flush_with_txn();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
